// File: rtl/block_ram_banked_sdp_pkg.sv
// ---------------------------------------------------------------------------
// block_ram_banked_sdp_pkg
// Shared constants and helpers for the banked simple-dual-port block RAM.
//   clogb2                 : ceil(log2(depth)), never less than 1.
//   RL_REG_ADDR / RL_REG_OUT: the two legal read latencies (1 and 2 clocks).
//   WF_READ_FIRST / WF_WRITE_FIRST: same-address read/write collision modes.
// ---------------------------------------------------------------------------
package block_ram_banked_sdp_pkg;

    localparam int RL_REG_ADDR    = 1;  // registered address, data one clock later
    localparam int RL_REG_OUT     = 2;  // extra output register on top of that

    localparam int WF_READ_FIRST  = 0;  // colliding read returns the old word
    localparam int WF_WRITE_FIRST = 1;  // colliding read returns old word merged with new bytes

    // Address width needed to reach depth-1. A depth of 2 needs one bit, and
    // the result is clamped to 1 so a degenerate depth still gives a legal port.
    function automatic int clogb2(input int depth);
        int width;
        width = 0;
        for (int i = 0; i < 31; i++) begin
            if (((depth - 1) >> i) != 0) begin
                width = i + 1;
            end
        end
        if (width < 1) begin
            width = 1;
        end
        return width;
    endfunction

    function automatic bit legal_read_latency(input int latency);
        return (latency == RL_REG_ADDR) || (latency == RL_REG_OUT);
    endfunction

endpackage

// File: rtl/block_ram_banked_sdp_if.sv
// ---------------------------------------------------------------------------
// block_ram_banked_sdp_if
// Flattened per-bank write/read bus of the banked RAM. Bank b occupies
// slice [b*W +: W] of every vector.
//   wr_en/wr_addr/wr_data/wr_be : write port, driven by the master
//   rd_en/rd_addr               : read request, driven by the master
//   rd_data/rd_valid            : read response, driven by the RAM (slave)
// ---------------------------------------------------------------------------
interface block_ram_banked_sdp_if
    import block_ram_banked_sdp_pkg::*;
#(
    parameter int NUM_BANKS  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DATA_DEPTH = 256
);
    localparam int ADDR_W = clogb2(DATA_DEPTH);
    localparam int BE_W   = DATA_WIDTH / 8;

    logic [NUM_BANKS-1:0]            wr_en;
    logic [NUM_BANKS*ADDR_W-1:0]     wr_addr;
    logic [NUM_BANKS*DATA_WIDTH-1:0] wr_data;
    logic [NUM_BANKS*BE_W-1:0]       wr_be;
    logic [NUM_BANKS-1:0]            rd_en;
    logic [NUM_BANKS*ADDR_W-1:0]     rd_addr;
    logic [NUM_BANKS*DATA_WIDTH-1:0] rd_data;
    logic [NUM_BANKS-1:0]            rd_valid;

    modport master (
        output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        input  rd_data, rd_valid
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        output rd_data, rd_valid
    );

endinterface

// File: rtl/block_ram_sdp_bank.sv
// ---------------------------------------------------------------------------
// block_ram_sdp_bank
// One simple-dual-port RAM bank: byte-enabled write port, read port with
// 1 or 2 clocks of latency, registered collision bypass and a valid strobe.
//   clk, rst_n          : clock, asynchronous active-low reset (pipeline only)
//   wr_en/addr/data/be  : write request; out-of-range addresses are dropped
//   rd_en/rd_addr       : read request; out-of-range reads return zero
//   rd_data/rd_valid    : response READ_LATENCY clocks after rd_en;
//                         rd_data holds between responses
// ---------------------------------------------------------------------------
module block_ram_sdp_bank
    import block_ram_banked_sdp_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int DATA_DEPTH   = 256,
    parameter int READ_LATENCY = RL_REG_ADDR,
    parameter int WRITE_FIRST  = WF_READ_FIRST,
    parameter int ADDR_W       = clogb2(DATA_DEPTH),
    parameter int BE_W         = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [BE_W-1:0]       wr_be,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
);

    // One extra bit so DATA_DEPTH itself is representable for the range test.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DATA_DEPTH);

    (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

    logic                  wr_hit;
    logic                  rd_hit;
    logic                  collide;
    logic [DATA_WIDTH-1:0] mem_rd_q;

    // Stage-1 side information travelling alongside the BRAM read register.
    logic                  valid1_q,    valid1_d;
    logic                  zero1_q,     zero1_d;      // force zero: out-of-range read or post-reset
    logic [BE_W-1:0]       byp_be1_q,   byp_be1_d;    // bytes to take from the colliding write
    logic [DATA_WIDTH-1:0] byp_data1_q, byp_data1_d;
    logic [DATA_WIDTH-1:0] stage1_data;

    assign wr_hit  = wr_en && ({1'b0, wr_addr} < DEPTH_L) && (wr_be != '0);
    assign rd_hit  = rd_en && ({1'b0, rd_addr} < DEPTH_L);
    assign collide = wr_hit && rd_hit && (wr_addr == rd_addr);

    // RAM array: no reset, so the tools can map it onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_hit) begin
            for (int i = 0; i < BE_W; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
                end
            end
        end
    end

    // Synchronous read; the array model returns the pre-write word on a
    // collision and the bypass below supplies the new bytes when wanted.
    always_ff @(posedge clk) begin
        if (rd_hit) begin
            mem_rd_q <= mem[rd_addr];
        end
    end

    // Side registers only move on a read so rd_data holds while idle.
    always_comb begin
        valid1_d    = rd_en;
        zero1_d     = zero1_q;
        byp_be1_d   = byp_be1_q;
        byp_data1_d = byp_data1_q;
        if (rd_en) begin
            zero1_d     = !rd_hit;
            byp_be1_d   = ((WRITE_FIRST == WF_WRITE_FIRST) && collide) ? wr_be : '0;
            byp_data1_d = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid1_q    <= 1'b0;
            zero1_q     <= 1'b1;   // masks the unreset BRAM register until the first read
            byp_be1_q   <= '0;
            byp_data1_q <= '0;
        end else begin
            valid1_q    <= valid1_d;
            zero1_q     <= zero1_d;
            byp_be1_q   <= byp_be1_d;
            byp_data1_q <= byp_data1_d;
        end
    end

    // Byte-wise bypass mux.
    for (genvar gi = 0; gi < BE_W; gi++) begin : g_byte
        assign stage1_data[gi*8 +: 8] = zero1_q        ? 8'h00 :
                                        byp_be1_q[gi]  ? byp_data1_q[gi*8 +: 8] :
                                                         mem_rd_q[gi*8 +: 8];
    end

    if (READ_LATENCY == RL_REG_OUT) begin : g_lat2
        logic [DATA_WIDTH-1:0] data2_q, data2_d;
        logic                  valid2_q, valid2_d;

        always_comb begin
            valid2_d = valid1_q;
            data2_d  = valid1_q ? stage1_data : data2_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid2_q <= 1'b0;
                data2_q  <= '0;
            end else begin
                valid2_q <= valid2_d;
                data2_q  <= data2_d;
            end
        end

        assign rd_data  = data2_q;
        assign rd_valid = valid2_q;
    end else begin : g_lat1
        assign rd_data  = stage1_data;
        assign rd_valid = valid1_q;
    end

endmodule

// File: rtl/block_ram_banked_sdp.sv
// ---------------------------------------------------------------------------
// block_ram_banked_sdp
// NUM_BANKS independent simple-dual-port RAM banks, one per channel lane.
//   clk   : single clock for every bank and both ports
//   rst_n : asynchronous active-low reset of the read pipelines
//   bus   : slave side of block_ram_banked_sdp_if; bank b uses slice b of
//           every vector (wr_*, rd_en, rd_addr in; rd_data, rd_valid out)
// ---------------------------------------------------------------------------
module block_ram_banked_sdp
    import block_ram_banked_sdp_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int DATA_DEPTH   = 256,
    parameter int NUM_BANKS    = 4,
    parameter int READ_LATENCY = RL_REG_ADDR,
    parameter int WRITE_FIRST  = WF_READ_FIRST
) (
    input  logic                 clk,
    input  logic                 rst_n,
    block_ram_banked_sdp_if.slave bus
);

    localparam int ADDR_W = clogb2(DATA_DEPTH);
    localparam int BE_W   = DATA_WIDTH / 8;

    if (DATA_WIDTH % 8 != 0) begin : g_bad_width
        $error("block_ram_banked_sdp: DATA_WIDTH (%0d) must be a multiple of 8", DATA_WIDTH);
    end
    if (!legal_read_latency(READ_LATENCY)) begin : g_bad_latency
        $error("block_ram_banked_sdp: READ_LATENCY (%0d) must be 1 or 2", READ_LATENCY);
    end
    if ((WRITE_FIRST != WF_READ_FIRST) && (WRITE_FIRST != WF_WRITE_FIRST)) begin : g_bad_mode
        $error("block_ram_banked_sdp: WRITE_FIRST (%0d) must be 0 or 1", WRITE_FIRST);
    end
    if (DATA_DEPTH < 2) begin : g_bad_depth
        $error("block_ram_banked_sdp: DATA_DEPTH (%0d) must be at least 2", DATA_DEPTH);
    end

    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
        logic [DATA_WIDTH-1:0] bank_rd_data;
        logic                  bank_rd_valid;

        block_ram_sdp_bank #(
            .DATA_WIDTH   (DATA_WIDTH),
            .DATA_DEPTH   (DATA_DEPTH),
            .READ_LATENCY (READ_LATENCY),
            .WRITE_FIRST  (WRITE_FIRST),
            .ADDR_W       (ADDR_W),
            .BE_W         (BE_W)
        ) u_bank (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_en    (bus.wr_en[gi]),
            .wr_addr  (bus.wr_addr[gi*ADDR_W +: ADDR_W]),
            .wr_data  (bus.wr_data[gi*DATA_WIDTH +: DATA_WIDTH]),
            .wr_be    (bus.wr_be[gi*BE_W +: BE_W]),
            .rd_en    (bus.rd_en[gi]),
            .rd_addr  (bus.rd_addr[gi*ADDR_W +: ADDR_W]),
            .rd_data  (bank_rd_data),
            .rd_valid (bank_rd_valid)
        );

        assign bus.rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = bank_rd_data;
        assign bus.rd_valid[gi]                         = bank_rd_valid;
    end

endmodule

// File: tb/tb_block_ram_banked_sdp.sv
// ---------------------------------------------------------------------------
// tb_block_ram_banked_sdp
// Two configurations driven with identical stimulus:
//   dut_a : depth 256, READ_LATENCY 1, read-first collisions
//   dut_b : depth 200, READ_LATENCY 2, write-first collisions
// A behavioural memory model predicts every read when it is issued and
// pushes it to a per-lane queue; responses are popped and compared.
// ---------------------------------------------------------------------------
module tb_block_ram_banked_sdp;

    localparam int NB = 4;
    localparam int DW = 32;
    localparam int AW = 8;

    typedef struct packed {
        int          due;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [NB-1:0]    wr_en;
    logic [NB*AW-1:0] wr_addr;
    logic [NB*DW-1:0] wr_data;
    logic [NB*4-1:0]  wr_be;
    logic [NB-1:0]    rd_en;
    logic [NB*AW-1:0] rd_addr;

    int n_checks = 0;
    int n_fail   = 0;
    int n        = 0;   // negedge counter

    logic [31:0] mdl [2][NB][256];
    exp_t        sb_q [2*NB][$];
    logic [31:0] last_data [2*NB];

    always #5 clk = ~clk;

    block_ram_banked_sdp_if #(.NUM_BANKS(NB), .DATA_WIDTH(DW), .DATA_DEPTH(256)) if_a ();
    block_ram_banked_sdp_if #(.NUM_BANKS(NB), .DATA_WIDTH(DW), .DATA_DEPTH(200)) if_b ();

    assign if_a.wr_en = wr_en;  assign if_a.wr_addr = wr_addr;  assign if_a.wr_data = wr_data;
    assign if_a.wr_be = wr_be;  assign if_a.rd_en   = rd_en;    assign if_a.rd_addr = rd_addr;
    assign if_b.wr_en = wr_en;  assign if_b.wr_addr = wr_addr;  assign if_b.wr_data = wr_data;
    assign if_b.wr_be = wr_be;  assign if_b.rd_en   = rd_en;    assign if_b.rd_addr = rd_addr;

    block_ram_banked_sdp #(
        .DATA_WIDTH(DW), .DATA_DEPTH(256), .NUM_BANKS(NB), .READ_LATENCY(1), .WRITE_FIRST(0)
    ) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));

    block_ram_banked_sdp #(
        .DATA_WIDTH(DW), .DATA_DEPTH(200), .NUM_BANKS(NB), .READ_LATENCY(2), .WRITE_FIRST(1)
    ) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] dut_data(input int d, input int b);
        logic [NB*DW-1:0] v;
        v = (d == 0) ? if_a.rd_data : if_b.rd_data;
        return v[b*DW +: DW];
    endfunction

    function automatic logic dut_valid(input int d, input int b);
        logic [NB-1:0] v;
        v = (d == 0) ? if_a.rd_valid : if_b.rd_valid;
        return v[b];
    endfunction

    // Predict reads (against the pre-write contents), then commit writes.
    task automatic model_step();
        int          depth, rl;
        bit          wf;
        int          ra, wa;
        logic [31:0] e;
        for (int d = 0; d < 2; d++) begin
            depth = (d == 0) ? 256 : 200;
            rl    = (d == 0) ? 1 : 2;
            wf    = (d == 1);
            for (int b = 0; b < NB; b++) begin
                ra = int'(rd_addr[b*AW +: AW]);
                wa = int'(wr_addr[b*AW +: AW]);
                if (rd_en[b]) begin
                    if (ra >= depth) e = 32'h0;
                    else begin
                        e = mdl[d][b][ra];
                        if (wf && wr_en[b] && wa == ra) e = merge(e, wr_data[b*DW +: DW], wr_be[b*4 +: 4]);
                    end
                    sb_q[d*NB+b].push_back('{due: n + rl, data: e});
                end
            end
            for (int b = 0; b < NB; b++) begin
                wa = int'(wr_addr[b*AW +: AW]);
                if (wr_en[b] && wa < depth)
                    mdl[d][b][wa] = merge(mdl[d][b][wa], wr_data[b*DW +: DW], wr_be[b*4 +: 4]);
            end
        end
    endtask

    task automatic check_outputs();
        int   idx;
        logic exp_v;
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            for (int b = 0; b < NB; b++) begin
                idx   = d * NB + b;
                exp_v = (sb_q[idx].size() > 0) && (sb_q[idx][0].due == n);
                check_eq($sformatf("valid d%0d b%0d", d, b), 64'(dut_valid(d, b)), 64'(exp_v));
                if (exp_v) begin
                    e = sb_q[idx].pop_front();
                    check_eq($sformatf("data d%0d b%0d", d, b), 64'(dut_data(d, b)), 64'(e.data));
                    last_data[idx] = e.data;
                    $display("rd dut%0d bank%0d cyc %0d data %h", d, b, n, dut_data(d, b));
                end else begin
                    check_eq($sformatf("hold d%0d b%0d", d, b), 64'(dut_data(d, b)), 64'(last_data[idx]));
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        n++;
        check_outputs();
    endtask

    task automatic idle();
        wr_en = '0; rd_en = '0; wr_be = '0;
        wr_addr = '0; rd_addr = '0; wr_data = '0;
    endtask

    task automatic set_wr(input int b, input int addr, input logic [31:0] data, input logic [3:0] be);
        wr_en[b] = 1'b1;
        wr_addr[b*AW +: AW] = AW'(addr);
        wr_data[b*DW +: DW] = data;
        wr_be[b*4 +: 4] = be;
    endtask

    task automatic set_rd(input int b, input int addr);
        rd_en[b] = 1'b1;
        rd_addr[b*AW +: AW] = AW'(addr);
    endtask

    task automatic read_all(input int addr);
        for (int b = 0; b < NB; b++) set_rd(b, addr);
    endtask

    task automatic flush_scoreboard();
        for (int i = 0; i < 2*NB; i++) begin
            sb_q[i].delete();
            last_data[i] = 32'h0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int d = 0; d < 2; d++)
            for (int b = 0; b < NB; b++)
                for (int a = 0; a < 256; a++) mdl[d][b][a] = 32'h0;
        flush_scoreboard();
        idle();

        // Reset held for 5 clocks: outputs must be zero / not valid.
        rst_n = 1'b0;
        repeat (5) tick();
        rst_n = 1'b1;
        tick();

        // Initial contents read as zero.
        read_all(0); tick();
        idle(); repeat (3) tick();

        // Byte enables on bank 1 addr 5.
        set_wr(1, 5, 32'hAABBCCDD, 4'b1111); tick();
        idle(); set_wr(1, 5, 32'h11223344, 4'b0101); tick();
        idle(); read_all(5); tick();
        idle(); repeat (3) tick();

        // Collision: addr 7 = 1, then write 2 + read same cycle, then read again.
        for (int b = 0; b < NB; b++) set_wr(b, 7, 32'h1, 4'hF);
        tick();
        idle();
        for (int b = 0; b < NB; b++) set_wr(b, 7, 32'h2, 4'hF);
        read_all(7); tick();
        idle(); read_all(7); tick();
        idle(); repeat (3) tick();

        // Back-to-back pipelined reads of addr 0..9, then a gap, then one read.
        for (int i = 0; i < 10; i++) begin
            idle(); set_wr(2, i, 32'h100 + i, 4'hF); tick();
        end
        for (int i = 0; i < 10; i++) begin
            idle(); read_all(i); tick();
        end
        idle(); repeat (2) tick();
        read_all(3); tick();
        idle(); repeat (3) tick();

        // Depth boundary: 199 in range for both, 200 dropped only in dut_b.
        set_wr(3, 199, 32'hFF, 4'hF); tick();
        idle(); set_wr(3, 200, 32'hEE, 4'hF); tick();
        idle(); read_all(199); tick();
        idle(); read_all(200); tick();
        idle(); read_all(0); tick();
        idle(); repeat (3) tick();

        // Reset with reads in flight: valid must drop without waiting for a clock.
        read_all(7); tick();
        read_all(5); tick();
        idle();
        rst_n = 1'b0;
        #1;
        for (int b = 0; b < NB; b++) begin
            check_eq($sformatf("rst valid a b%0d", b), 64'(dut_valid(0, b)), 64'd0);
            check_eq($sformatf("rst valid b b%0d", b), 64'(dut_valid(1, b)), 64'd0);
        end
        flush_scoreboard();
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        read_all(5); tick();
        idle(); repeat (3) tick();

        // Random traffic across all banks, including out-of-range addresses.
        for (int c = 0; c < 200; c++) begin
            idle();
            for (int b = 0; b < NB; b++) begin
                if ($urandom_range(0, 1) == 1)
                    set_wr(b, $urandom_range(0, 255), $urandom, 4'($urandom_range(0, 15)));
                if ($urandom_range(0, 2) != 0)
                    set_rd(b, $urandom_range(0, 255));
            end
            tick();
        end
        idle(); repeat (4) tick();

        for (int i = 0; i < 2*NB; i++)
            check_eq($sformatf("drain q%0d", i), 64'(sb_q[i].size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
